mem_clk_reset_seq: RTL

// - Consumer side of the memory rPLL: qualifies PLL lock and checks the PLL output frequency.
// - Releases the DRAM-domain reset only when the PLL is trusted.
// - Runs on the free-running crystal clock; samples the async PLL lock and a toggle derived from the PLL output.
// - Sequences memory-controller reset; requests a PLL reset on lock timeout or bad frequency.

---
 rtl/mem_clk_reset_seq.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/mem_clk_reset_seq.sv
// Memory rPLL consumer: qualifies lock, measures PLL frequency, sequences mem_rst.
// MEM_CLK_MON_CONT_EN keeps re-measuring the frequency while in RUN.
module mem_clk_reset_seq #(
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int LOCK_TIMEOUT       = 65535,
  parameter int WINDOW_CYCLES      = 4096,
  parameter int TGL_MIN            = 3400,
  parameter int TGL_MAX            = 3600,
  parameter int PLL_RST_CYCLES     = 16,
  parameter int SYNC_STAGES        = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pll_lock,
  input  logic        fb_tgl,
  output logic        pll_rst,
  output logic        mem_rst,
  output logic        ready,
  output logic        freq_err,
  output logic [15:0] freq_cnt,
  output logic [7:0]  lost_cnt
);

`ifdef MEM_CLK_MON_CONT_EN
  localparam bit CONT_EN = 1'b1;
`else
  localparam bit CONT_EN = 1'b0;
`endif

  localparam int TW = $clog2(LOCK_TIMEOUT + 1);
  localparam int SW = $clog2(LOCK_STABLE_CYCLES + 1);
  localparam int WW = $clog2(WINDOW_CYCLES + 1);
  localparam int PW = $clog2(PLL_RST_CYCLES + 1);

  localparam logic [TW-1:0] TMO_LAST   = TW'(LOCK_TIMEOUT - 1);
  localparam logic [SW-1:0] STAB_LAST  = SW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [WW-1:0] WIN_LAST   = WW'(WINDOW_CYCLES - 1);
  localparam logic [PW-1:0] PULSE_LAST = PW'(PLL_RST_CYCLES - 1);
  localparam logic [15:0]   TGL_LO     = 16'(TGL_MIN);
  localparam logic [15:0]   TGL_HI     = 16'(TGL_MAX);

  typedef enum logic [2:0] {
    ST_WAIT_LOCK,
    ST_STABLE,
    ST_CHECK,
    ST_RUN,
    ST_PLL_RST
  } state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] lock_sync_q, lock_sync_d;
  logic [SYNC_STAGES-1:0] tgl_sync_q, tgl_sync_d;
  logic [TW-1:0]          tmo_cnt_q, tmo_cnt_d;
  logic [SW-1:0]          stab_cnt_q, stab_cnt_d;
  logic [WW-1:0]          win_cnt_q, win_cnt_d;
  logic [PW-1:0]          pulse_cnt_q, pulse_cnt_d;
  logic [15:0]            edge_cnt_q, edge_cnt_d;
  logic                   freq_err_q, freq_err_d;
  logic [15:0]            freq_cnt_q, freq_cnt_d;
  logic [7:0]             lost_cnt_q, lost_cnt_d;

  logic        lk;
  logic        tgl_edge;
  logic [15:0] edge_sum;
  logic        in_range;
  logic        lost_evt;

  assign lk       = lock_sync_q[SYNC_STAGES-1];
  assign tgl_edge = tgl_sync_q[SYNC_STAGES-1] ^ tgl_sync_q[SYNC_STAGES-2];
  assign edge_sum = (tgl_edge && (edge_cnt_q != 16'hFFFF)) ? edge_cnt_q + 16'd1 : edge_cnt_q;
  assign in_range = (edge_sum >= TGL_LO) && (edge_sum <= TGL_HI);

  // Counters default to zero so every state change starts them afresh.
  always_comb begin
    state_d     = state_q;
    lock_sync_d = {lock_sync_q[SYNC_STAGES-2:0], pll_lock};
    tgl_sync_d  = {tgl_sync_q[SYNC_STAGES-2:0], fb_tgl};
    tmo_cnt_d   = '0;
    stab_cnt_d  = '0;
    win_cnt_d   = '0;
    pulse_cnt_d = '0;
    edge_cnt_d  = '0;
    freq_err_d  = freq_err_q;
    freq_cnt_d  = freq_cnt_q;
    lost_cnt_d  = lost_cnt_q;
    lost_evt    = 1'b0;

    case (state_q)
      ST_WAIT_LOCK: begin
        if (lk) begin
          state_d = ST_STABLE;
        end else if (tmo_cnt_q == TMO_LAST) begin
          state_d = ST_PLL_RST;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TW'(1);
        end
      end
      ST_STABLE: begin
        if (!lk) begin
          lost_evt = 1'b1;
          state_d  = ST_WAIT_LOCK;
        end else if (stab_cnt_q == STAB_LAST) begin
          freq_err_d = 1'b0;
          state_d    = ST_CHECK;
        end else begin
          stab_cnt_d = stab_cnt_q + SW'(1);
        end
      end
      // Lock loss takes priority over a window that ends on the same cycle.
      ST_CHECK: begin
        if (!lk) begin
          lost_evt = 1'b1;
          state_d  = ST_WAIT_LOCK;
        end else if (win_cnt_q == WIN_LAST) begin
          freq_cnt_d = edge_sum;
          if (in_range) begin
            state_d = ST_RUN;
          end else begin
            freq_err_d = 1'b1;
            state_d    = ST_PLL_RST;
          end
        end else begin
          win_cnt_d  = win_cnt_q + WW'(1);
          edge_cnt_d = edge_sum;
        end
      end
      ST_RUN: begin
        if (!lk) begin
          lost_evt = 1'b1;
          state_d  = ST_WAIT_LOCK;
        end else if (CONT_EN) begin
          if (win_cnt_q == WIN_LAST) begin
            freq_cnt_d = edge_sum;
            if (!in_range) begin
              freq_err_d = 1'b1;
              state_d    = ST_PLL_RST;
            end
          end else begin
            win_cnt_d  = win_cnt_q + WW'(1);
            edge_cnt_d = edge_sum;
          end
        end
      end
      ST_PLL_RST: begin
        if (pulse_cnt_q == PULSE_LAST) begin
          state_d = ST_WAIT_LOCK;
        end else begin
          pulse_cnt_d = pulse_cnt_q + PW'(1);
        end
      end
      default: state_d = ST_WAIT_LOCK;
    endcase

    if (lost_evt && (lost_cnt_q != 8'hFF)) begin
      lost_cnt_d = lost_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_WAIT_LOCK;
      lock_sync_q <= '0;
      tgl_sync_q  <= '0;
      tmo_cnt_q   <= '0;
      stab_cnt_q  <= '0;
      win_cnt_q   <= '0;
      pulse_cnt_q <= '0;
      edge_cnt_q  <= '0;
      freq_err_q  <= 1'b0;
      freq_cnt_q  <= '0;
      lost_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      lock_sync_q <= lock_sync_d;
      tgl_sync_q  <= tgl_sync_d;
      tmo_cnt_q   <= tmo_cnt_d;
      stab_cnt_q  <= stab_cnt_d;
      win_cnt_q   <= win_cnt_d;
      pulse_cnt_q <= pulse_cnt_d;
      edge_cnt_q  <= edge_cnt_d;
      freq_err_q  <= freq_err_d;
      freq_cnt_q  <= freq_cnt_d;
      lost_cnt_q  <= lost_cnt_d;
    end
  end

  assign pll_rst  = (state_q == ST_PLL_RST);
  assign mem_rst  = (state_q != ST_RUN);
  assign ready    = (state_q == ST_RUN);
  assign freq_err = freq_err_q;
  assign freq_cnt = freq_cnt_q;
  assign lost_cnt = lost_cnt_q;

endmodule
